// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: packed ControlUnit bundle layout and the
// bit positions of each control field, MSB first.
package rv_pipe_pkg;

  localparam int CTRL_W = 18;

  localparam int CB_REG_WRITE  = 17;
  localparam int CB_MEM_TO_REG = 16;
  localparam int CB_JAL        = 15;
  localparam int CB_MEM_READ   = 14;
  localparam int CB_MEM_WRITE  = 13;
  localparam int CB_IS_BRANCH  = 12;
  localparam int CB_ALU_SRC    = 11;
  localparam int CB_BR_TYPE    = 10;
  localparam int CB_JALR       = 9;
  localparam int CB_IMM_SRC_LO = 7;
  localparam int CB_ALU_OP_LO  = 4;
  localparam int CB_MEM_SZ_LO  = 2;
  localparam int CB_LD_SZ_LO   = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       alu_src;
    logic       branch_type;
    logic       jalr;
    logic [1:0] imm_src;
    logic [2:0] alu_op;
    logic [1:0] mem_size;
    logic [1:0] load_size;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detect: a load in EX whose rd feeds the ID instruction.
// Purely combinational; x0 never matches.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  output logic              o_hz
);

  logic w_rd_nz;
  logic w_match;

  assign w_rd_nz = |i_ex_rd;

  // rs2 is always compared; an I-type may stall falsely
  assign w_match = (i_ex_rd == i_id_rs1)
                 | (i_ex_rd == i_id_rs2);

  assign o_hz = i_ex_valid
              & i_ex_mem_read
              & w_rd_nz
              & i_id_valid
              & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, flush and hold.
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              load_use_stall_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubbles_o,
  output logic [31:0]       perf_flushes_o
`endif
);

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;

  ctrl_t             w_id_ctrl;
  logic              w_hz;
  logic              w_bubble;

  assign w_id_ctrl = ctrl_t'(id_ctrl_i);

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid_i),
    .i_id_rs1      (id_rs1_i),
    .i_id_rs2      (id_rs2_i),
    .o_hz          (w_hz)
  );

  // flush and hold both pre-empt the bubble
  assign w_bubble = w_hz & ~flush_i & ~hold_i;

  assign load_use_stall_o = w_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
    end else if (hold_i) begin
      r_valid    <= r_valid;
    end else if (w_hz) begin
      // ID is frozen upstream and re-presented next cycle
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
    end else begin
      r_valid    <= id_valid_i;
      r_ctrl     <= id_valid_i ? w_id_ctrl : CTRL_NOP;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_ctrl_o     = r_ctrl;
  assign ex_pc_o       = r_pc;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_rs1_o      = r_rs1;
  assign ex_rs2_o      = r_rs2;
  assign ex_rd_o       = r_rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_flushes;

  // saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_bubble && (r_perf_bubbles != 32'hFFFF_FFFF))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (flush_i && (r_perf_flushes != 32'hFFFF_FFFF))
        r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_bubbles_o = r_perf_bubbles;
  assign perf_flushes_o = r_perf_flushes;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register, directly downstream of the ControlUnit and decode logic.
- Captures the decoded control bundle, the operands and the register addresses each cycle.
- Detects load-use hazards against the instruction it currently holds in EX. On a hazard it requests an upstream stall and inserts a bubble.
- Handles branch/jump flush from EX and an external hold from later stages.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- REG_AW, 5, register-address width.
- CTRL_W, 18, width of the packed control bundle (fixed by the package; not to be overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_ctrl_i  in  CTRL_W  packed ControlUnit outputs. Packing MSB→LSB: RegWriteEn, MemtoReg, JAL, MemReadEn, MemWriteEn, IsBranch, ALUSrc, BranchType, JALR, ImmSrc[1:0], ALUOp[2:0], MemSize[1:0], LoadSize[1:0].
- id_pc_i  in  XLEN  PC of the ID instruction.
- id_rs1_data_i  in  XLEN  register-file read port 1.
- id_rs2_data_i  in  XLEN  register-file read port 2.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_rs1_i  in  REG_AW  source register 1 address.
- id_rs2_i  in  REG_AW  source register 2 address.
- id_rd_i  in  REG_AW  destination register address.
- flush_i  in  1  taken branch/jump resolved in EX; the ID instruction is wrong-path.
- hold_i  in  1  downstream stall; freeze this register.
- load_use_stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_ctrl_o  out  CTRL_W  registered control bundle.
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  registered data.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_AW  registered addresses, also used by forwarding.

Behaviour:
- Reset: rst=1 at a clock edge clears every registered output to 0, including ex_valid_o and ex_ctrl_o. rst has priority over all other inputs.
- Reset mid-operation: any instruction in EX is discarded with no partial effect.
- Hazard term, combinational:
  - hz = ex_valid_o & MemReadEn(ex_ctrl_o) & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)).
  - The rs2 comparison is always made. A false stall on an I-type instruction is accepted behaviour.
- load_use_stall_o = hz & ~flush_i & ~hold_i.
- Next-state priority, evaluated each edge:
  1. rst: clear all registers.
  2. flush_i: ex_valid_o=0 and ex_ctrl_o=0; data and address registers take the ID values. flush_i overrides hold_i, because the EX instruction is committing the redirect.
  3. hold_i: all registers keep their value.
  4. hz: insert a bubble (ex_valid_o=0, ex_ctrl_o=0); data registers keep their value. The ID instruction is re-presented next cycle because upstream is frozen.
  5. Otherwise: load all ID inputs. ex_valid_o = id_valid_i. ex_ctrl_o = id_ctrl_i if id_valid_i, else 0.
- Bubble invariant: ex_valid_o=0 implies ex_ctrl_o=0, so no RegWriteEn, MemWriteEn, IsBranch, JAL or JALR leak out of a bubble.
- Latency: one cycle from ID to EX.
- A load-use hazard produces exactly one bubble. In the following cycle EX holds the bubble, so hz=0.
- Back-to-back loads each get an independent check.
- x0: ex_rd_o=0 never raises a hazard.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbles_o[31:0] and perf_flushes_o[31:0].
  - perf_bubbles_o increments on each edge where priority 4 is taken; perf_flushes_o increments where priority 2 is taken.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the ports and the counter logic are absent.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - CTRL_W and the bit-index localparams for each control field.
  - A ctrl_t packed struct matching the ControlUnit field order.
  - CTRL_NOP = 0.
- One sub-module, hazard_detect: purely combinational, producing hz from the EX and ID fields.
- The register itself stays in id_ex_stage.

Test Plan:
- Reset: drive all inputs nonzero with rst=1 for 2 cycles → all outputs 0; release rst → the next edge loads the ID values.
- Pass-through: id_valid_i=1, ctrl = ADD R-type (RegWriteEn=1), pc=0x100 → ex_pc_o=0x100 one cycle later, ex_ctrl_o equal to the input, load_use_stall_o=0.
- Load-use hazard:
  - Stimulus: LW with rd=5 in EX, then ID instruction with rs1=5.
  - Response: load_use_stall_o=1 for exactly one cycle; next EX is a bubble (ex_valid_o=0, ctrl=0); the following edge loads the held ID instruction.
- x0 and no match: LW with rd=0, ID rs1=0 → no stall. LW with rd=5, ID rs1=6, rs2=7 → no stall.
- Flush vs hold vs hazard:
  - flush_i=1, hold_i=1 and hz=1 together → load_use_stall_o=0 and next ex_valid_o=0.
  - hold_i=1 alone for 3 cycles → outputs constant.
- With ID_EX_PERF_CNT_EN defined:
  - 2 hazards and 3 flushes → perf_bubbles_o=2, perf_flushes_o=3.
  - Counter forced to 0xFFFF_FFFF, then one more hazard → counter stays 0xFFFF_FFFF.
